alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req0_valid, req1_valid  in  1  requester i presents an operation.
REQ-005 req0_ready, req1_ready  out  1  arbiter accepts requester i's operation this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  in  WIDTH  signed operands.
REQ-007 req0_op, req1_op  in  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-008 alu_a, alu_b  out  WIDTH  operands driven to the shared combinational ALU.
REQ-009 alu_op  out  3  opcode driven to the shared ALU.
REQ-010 alu_z  in  WIDTH  combinational ALU result.
REQ-011 rsp0_valid, rsp1_valid  out  1  result for requester i is available.
REQ-012 rsp0_ready, rsp1_ready  in  1  requester i consumes its result.
REQ-013 rsp_z  out  WIDTH  result, shared by both response ports and qualified by rspN_valid.
REQ-014 rsp_err  out  1  the accepted opcode was illegal; qualified by rspN_valid.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-016 In IDLE, reqN_ready SHALL be high only for the granted requester; both SHALL be low in EXEC and RESP.
REQ-017 Grant SHALL be round-robin: with a single valid request, that request wins; with both valid, the requester named by pointer prio wins.
REQ-018 On acceptance (IDLE, valid&ready), the block SHALL capture a, b, op and requester id, and set prio to the other requester.
REQ-019 Acceptance SHALL move the FSM from IDLE to EXEC.
REQ-020 In EXEC, alu_a/alu_b/alu_op SHALL be driven from the captured registers and alu_z SHALL be registered into rsp_z; the FSM SHALL then move to RESP.
REQ-021 In all other states, alu_a, alu_b and alu_op SHALL be driven to 0.
REQ-022 Latency: acceptance in cycle N gives rspN_valid high in cycle N+2.
REQ-023 In RESP, rspN_valid SHALL be high only for the captured id; rsp_z and rsp_err SHALL stay stable until rspN_ready.
REQ-024 RESP with rspN_ready high for the captured id SHALL return the FSM to IDLE in the next cycle, so the next acceptance is possible at N+3 at the earliest.
REQ-025 rspN_ready for the non-captured id SHALL be ignored.
REQ-026 An illegal opcode (011, 100, 101) SHALL still be accepted and pass through EXEC with alu_op forced to 000.
REQ-027 For an illegal opcode, the response SHALL carry rsp_z = 0 and rsp_err = 1.
REQ-028 A request that drops valid before acceptance SHALL be ignored; prio SHALL change only on acceptance.
REQ-029 Throughput SHALL be at most one operation per 3 cycles; no operation SHALL ever be lost or duplicated.

Reset
REQ-030 rst high at a clock edge SHALL force: state IDLE, prio 0, captured registers 0, rsp_z 0, rsp_err 0, rspN_valid 0.
REQ-031 Reset in EXEC or RESP SHALL discard the in-flight operation with no response.
REQ-032 While rst is high, reqN_ready SHALL be 0.

Structure
REQ-033 The opcode constants (AND, OR, ADD, SUB, SLT) and the FSM state encodings SHALL be defined in a shared package/include file used by ALU users.
REQ-034 The round-robin grant logic SHALL be the single sub-module rr_pick2 (inputs: two valids and prio; output: one-hot grant).

Verification
REQ-035 Single request: req0 ADD a=5, b=7 accepted at cycle N -> rsp0_valid at N+2 with rsp_z=12, rsp_err=0.
REQ-036 Simultaneous requests, both held: req0 SUB a=3, b=10 and req1 SLT a=-1, b=1 -> req0 served first (prio=0) with rsp_z=-7, then req1 with rsp_z=1.
REQ-037 Response backpressure: rsp1_ready held low for 5 cycles -> rsp_z stays constant, and no reqN_ready occurs until rsp1_ready rises.
REQ-038 Illegal opcode: req1 op=100 -> rsp1_valid with rsp_z=0 and rsp_err=1, and alu_op=000 during EXEC.
REQ-039 Reset mid-operation: rst asserted in EXEC -> no rspN_valid afterwards, prio=0, and the next request completes normally.
REQ-040 Fairness: both requesters continuously valid for 12 operations -> grants strictly alternate, 6 each.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared opcode constants, FSM state encoding and opcode legality helper
// for the shared-ALU arbiter and its users.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to the requester named by prio.
// Purely combinational; grant is one-hot or zero.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU: accept -> exec -> respond.
// One operation in flight; response held until the owning requester consumes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_z,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_err
);

  state_t           state, state_nxt;
  logic             prio;
  logic [WIDTH-1:0] cap_a, cap_b;
  logic [2:0]       cap_op;
  logic             cap_id;
  logic [1:0]       grant;
  logic             acc0, acc1;
  logic             cap_legal;

  rr_pick2 u_pick (
    .valid ({req1_valid, req0_valid}),
    .prio  (prio),
    .grant (grant)
  );

  assign acc0      = req0_valid && req0_ready;
  assign acc1      = req1_valid && req1_ready;
  assign cap_legal = op_legal(cap_op);

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = OP_AND;
    case (state)
      ST_IDLE: begin
        req0_ready = grant[0] && !rst;
        req1_ready = grant[1] && !rst;
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_a     = cap_a;
        alu_b     = cap_b;
        // Illegal opcodes still occupy the ALU slot, but with a harmless AND.
        alu_op    = cap_legal ? cap_op : OP_AND;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp0_valid = !cap_id;
        rsp1_valid = cap_id;
        if (cap_id ? rsp1_ready : rsp0_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      prio    <= 1'b0;
      cap_a   <= '0;
      cap_b   <= '0;
      cap_op  <= OP_AND;
      cap_id  <= 1'b0;
      rsp_z   <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc0 || acc1) begin
        cap_a  <= acc1 ? req1_a  : req0_a;
        cap_b  <= acc1 ? req1_b  : req0_b;
        cap_op <= acc1 ? req1_op : req0_op;
        cap_id <= acc1;
        prio   <= !acc1;
      end
      if (state == ST_EXEC) begin
        rsp_z   <= cap_legal ? alu_z : '0;
        rsp_err <= !cap_legal;
      end
    end
  end

endmodule
